rect_fill_engine: RTL and testbench

Hardware rectangle-fill engine that streams one colour into VRAM over an inclusive box (x0,y0)-(x1,y1). It replaces the CPU's software pixel loop (store colour, increment x, branch if less-or-equal, increment y, branch if less-or-equal). It sits between the CPU's drawing-command decode and the VRAM write port. Generalised over screen size and colour depth, with clipping, write backpressure and a busy/done handshake.

---
 rtl/rect_fill_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: streams one colour into VRAM over an inclusive,
// clipped box (x0,y0)-(x1,y1) in row-major order, one pixel per cycle.
//
// Ports:
//   Clock       rising-edge clock
//   Reset       asynchronous active-low reset
//   iStart      command strobe, sampled only in IDLE
//   iX0/iY0     top-left corner, inclusive
//   iX1/iY1     bottom-right corner, inclusive (clipped to the screen)
//   iColor      fill colour
//   iOutline    border-only fill (present only with RECT_FILL_OUTLINE_EN)
//   iVramReady  VRAM accepts the presented write this cycle
//   oBusy       command in progress
//   oDone       one-cycle completion pulse
//   oVramWE     write request
//   oVramAddr   write address (y*VRAM_W + x)
//   oVramData   write data
//
// Build option: define RECT_FILL_OUTLINE_EN to add the iOutline port.
module rect_fill_engine #(
    parameter int VRAM_W  = 80,
    parameter int VRAM_H  = 60,
    parameter int XW      = 7,
    parameter int YW      = 6,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 13
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [XW-1:0]      iX0,
    input  logic [YW-1:0]      iY0,
    input  logic [XW-1:0]      iX1,
    input  logic [YW-1:0]      iY1,
    input  logic [COLOR_W-1:0] iColor,
`ifdef RECT_FILL_OUTLINE_EN
    input  logic               iOutline,
`endif
    input  logic               iVramReady,
    output logic               oBusy,
    output logic               oDone,
    output logic               oVramWE,
    output logic [ADDR_W-1:0]  oVramAddr,
    output logic [COLOR_W-1:0] oVramData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [XW-1:0]     X_MAX    = XW'(VRAM_W - 1);
    localparam logic [YW-1:0]     Y_MAX    = YW'(VRAM_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(VRAM_W);

    state_t               state_q, state_d;
    logic [XW-1:0]        x0_q, x0_d;
    logic [YW-1:0]        y0_q, y0_d;
    // Hold the raw corner until SETUP, then the clipped corner.
    logic [XW-1:0]        x1_q, x1_d;
    logic [YW-1:0]        y1_q, y1_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 outline_q, outline_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [ADDR_W-1:0]    rowbase_q, rowbase_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COLOR_W-1:0]   data_q, data_d;

    logic                 outline_in;
    logic [XW-1:0]        x1c;
    logic [YW-1:0]        y1c;
    logic                 empty;
    logic [ADDR_W-1:0]    row0;
    logic                 accept;
    logic                 interior;
    logic [XW-1:0]        x_step;

`ifdef RECT_FILL_OUTLINE_EN
    assign outline_in = iOutline;
`else
    assign outline_in = 1'b0;
`endif

    assign x1c   = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign y1c   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    assign empty = (x0_q > x1c) || (y0_q > y1c) ||
                   (x0_q > X_MAX) || (y0_q > Y_MAX);

    // Only multiply in the whole engine; later rows add ROW_STEP.
    assign row0 = ADDR_W'(y0_q) * ROW_STEP;

    assign accept = we_q && iVramReady;

    // Interior outline rows visit only x0 and x1c, so the step from
    // x0 jumps straight to the clipped right edge.
    assign interior = outline_q && (y_q != y0_q) && (y_q != y1_q);
    assign x_step   = interior ? x1_q : x_q + XW'(1);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        color_d   = color_q;
        outline_d = outline_q;
        x_d       = x_q;
        y_d       = y_q;
        rowbase_d = rowbase_q;
        busy_d    = busy_q;
        done_d    = done_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;

        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (iStart) begin
                    x0_d      = iX0;
                    y0_d      = iY0;
                    x1_d      = iX1;
                    y1_d      = iY1;
                    color_d   = iColor;
                    outline_d = outline_in;
                    busy_d    = 1'b1;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                x1_d = x1c;
                y1_d = y1c;
                if (empty) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rowbase_d = row0;
                    x_d       = x0_q;
                    y_d       = y0_q;
                    we_d      = 1'b1;
                    addr_d    = row0 + ADDR_W'(x0_q);
                    data_d    = color_q;
                    state_d   = S_FILL;
                end
            end

            S_FILL: begin
                // Compare before increment so x never wraps past X_MAX.
                if (accept) begin
                    if (x_q < x1_q) begin
                        x_d    = x_step;
                        addr_d = rowbase_q + ADDR_W'(x_step);
                    end else if (y_q < y1_q) begin
                        x_d       = x0_q;
                        y_d       = y_q + YW'(1);
                        rowbase_d = rowbase_q + ROW_STEP;
                        addr_d    = rowbase_q + ROW_STEP + ADDR_W'(x0_q);
                    end else begin
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rowbase_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            color_q   <= color_d;
            outline_q <= outline_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rowbase_q <= rowbase_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oVramWE   = we_q;
    assign oVramAddr = addr_q;
    assign oVramData = data_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: table-driven and randomized checks of
// rect_fill_engine against a loop-based pixel-list model.
module tb_rect_fill_engine;

    localparam int VW = 80;
    localparam int VH = 60;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iStart = 1'b0;
    logic [6:0]  iX0 = '0;
    logic [5:0]  iY0 = '0;
    logic [6:0]  iX1 = '0;
    logic [5:0]  iY1 = '0;
    logic [2:0]  iColor = '0;
`ifdef RECT_FILL_OUTLINE_EN
    logic        iOutline = 1'b0;
`endif
    logic        iVramReady = 1'b1;
    logic        oBusy;
    logic        oDone;
    logic        oVramWE;
    logic [12:0] oVramAddr;
    logic [2:0]  oVramData;

    rect_fill_engine dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iStart     (iStart),
        .iX0        (iX0),
        .iY0        (iY0),
        .iX1        (iX1),
        .iY1        (iY1),
        .iColor     (iColor),
`ifdef RECT_FILL_OUTLINE_EN
        .iOutline   (iOutline),
`endif
        .iVramReady (iVramReady),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oVramWE    (oVramWE),
        .oVramAddr  (oVramAddr),
        .oVramData  (oVramData)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    int stall_pix     = -1;
    int stall_len     = 0;
    bit rand_ready    = 1'b0;
    int restart_k     = -1;
    bit start_in_done = 1'b0;

    typedef struct {
        int x0, y0, x1, y1, color;
        int n, first, last, done;
    } vec_t;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle N of the command.
    task automatic run_cmd(input int x0, input int y0, input int x1,
                           input int y1, input int color, input bit outl,
                           output int nw, output int first_a,
                           output int last_a, output int done_k,
                           output int max_a, output int hold1);
        int q[$];
        int x1c, y1c, k, req_k, last_k, sctr;
        bit prev_stall;
        int p_addr, p_data;
        x1c = (x1 > VW - 1) ? VW - 1 : x1;
        y1c = (y1 > VH - 1) ? VH - 1 : y1;
        if (x0 <= x1c && y0 <= y1c)
            for (int y = y0; y <= y1c; y++)
                for (int x = x0; x <= x1c; x++)
                    if (!outl || y == y0 || y == y1c || x == x0 || x == x1c)
                        q.push_back(y * VW + x);
        nw = 0; first_a = -1; last_a = -1; done_k = -1; max_a = -1;
        hold1 = 0; req_k = -1; last_k = -1; sctr = 0;
        prev_stall = 1'b0; p_addr = 0; p_data = 0;
        iStart = 1'b1;
        iX0 = 7'(x0); iY0 = 6'(y0); iX1 = 7'(x1); iY1 = 6'(y1);
        iColor = 3'(color);
`ifdef RECT_FILL_OUTLINE_EN
        iOutline = outl;
`endif
        @(negedge Clock);
        k = 1;
        while (done_k < 0 && k < 12000) begin
            iStart = 1'b0;
            if (prev_stall) begin
                check("hold_we", oVramWE, 1);
                check("hold_addr", oVramAddr, p_addr);
                check("hold_data", oVramData, p_data);
            end
            if (oVramWE && oVramAddr == 13'd1) hold1++;
            if (oDone) begin
                done_k = k;
                check("busy_at_done", oBusy, 0);
                check("we_at_done", oVramWE, 0);
                if (start_in_done) begin
                    iStart = 1'b1;
                    iX0 = 7'd0; iY0 = 6'd0; iX1 = 7'd5; iY1 = 6'd5;
                end
            end else begin
                check("busy_in_cmd", oBusy, 1);
            end
            if (oVramWE && req_k < 0) req_k = k;
            if (rand_ready)
                iVramReady = ($urandom_range(0, 2) != 0);
            else if (oVramWE && nw == stall_pix && sctr < stall_len) begin
                iVramReady = 1'b0;
                sctr++;
            end else
                iVramReady = 1'b1;
            if (oVramWE && iVramReady) begin
                if (nw < q.size()) check("addr", oVramAddr, q[nw]);
                else check("extra_write", oVramAddr, -1);
                check("data", oVramData, color);
                if (nw == 0) first_a = int'(oVramAddr);
                last_a = int'(oVramAddr);
                if (int'(oVramAddr) > max_a) max_a = int'(oVramAddr);
                last_k = k;
                nw++;
            end
            prev_stall = oVramWE && !iVramReady;
            p_addr = int'(oVramAddr);
            p_data = int'(oVramData);
            if (k == restart_k) begin
                iStart = 1'b1;
                iX0 = 7'd0; iY0 = 6'd0; iX1 = 7'd127; iY1 = 6'd63;
                iColor = 3'(color + 1);
            end
            @(negedge Clock);
            k++;
        end
        iStart = 1'b0;
        iVramReady = 1'b1;
        if (done_k < 0) check("timeout", k, -1);
        check("nwrites", nw, q.size());
        check("first_req_cycle", req_k, (q.size() > 0) ? 2 : -1);
        check("done_after_last", done_k, (q.size() > 0) ? last_k + 1 : 2);
        if (start_in_done) begin
            check("start_in_done_busy", oBusy, 0);
            check("start_in_done_done", oDone, 0);
            @(negedge Clock);
            check("start_in_done_busy2", oBusy, 0);
        end
    endtask

    vec_t tbl[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw, fa, la, dk, ma, h1;
        int rx0, ry0, rx1, ry1;

        tbl[0] = '{0, 0, 79, 59, 3, 4800, 0, 4799, 4802};
        tbl[1] = '{10, 5, 10, 5, 4, 1, 410, 410, 3};
        tbl[2] = '{70, 50, 100, 63, 5, 100, 4070, 4799, 102};
        tbl[3] = '{30, 10, 20, 40, 6, 0, -1, -1, 2};
        tbl[4] = '{85, 0, 90, 5, 7, 0, -1, -1, 2};

        #7;
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_we", oVramWE, 0);
        check("rst_addr", oVramAddr, 0);
        check("rst_data", oVramData, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 5; i++) begin
            run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
                    tbl[i].color, 1'b0, nw, fa, la, dk, ma, h1);
            check("tbl_nwrites", nw, tbl[i].n);
            check("tbl_first_addr", fa, tbl[i].first);
            check("tbl_last_addr", la, tbl[i].last);
            check("tbl_done_cycle", dk, tbl[i].done);
            if (tbl[i].n > 0) check("tbl_addr_in_screen", ma < VW * VH, 1);
        end

        stall_pix = 1; stall_len = 3;
        run_cmd(0, 0, 2, 0, 2, 1'b0, nw, fa, la, dk, ma, h1);
        stall_pix = -1; stall_len = 0;
        check("bp_nwrites", nw, 3);
        check("bp_addr1_hold", h1, 4);
        check("bp_first", fa, 0);
        check("bp_last", la, 2);

        restart_k = 4;
        run_cmd(0, 0, 4, 1, 2, 1'b0, nw, fa, la, dk, ma, h1);
        restart_k = -1;
        check("restart_nwrites", nw, 10);
        check("restart_done_cycle", dk, 12);

        start_in_done = 1'b1;
        run_cmd(3, 3, 3, 3, 1, 1'b0, nw, fa, la, dk, ma, h1);
        start_in_done = 1'b0;
        check("sid_addr", fa, 3 * VW + 3);

        iStart = 1'b1;
        iX0 = 7'd0; iY0 = 6'd0; iX1 = 7'd9; iY1 = 6'd9; iColor = 3'd5;
        @(negedge Clock);
        iStart = 1'b0;
        repeat (5) @(negedge Clock);
        check("pre_reset_we", oVramWE, 1);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_busy", oBusy, 0);
        check("mid_rst_done", oDone, 0);
        check("mid_rst_we", oVramWE, 0);
        check("mid_rst_addr", oVramAddr, 0);
        check("mid_rst_data", oVramData, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("in_rst_we", oVramWE, 0);
            check("in_rst_done", oDone, 0);
        end
        Reset = 1'b1;
        @(negedge Clock);
        check("post_rst_idle", oBusy, 0);
        run_cmd(10, 5, 10, 5, 4, 1'b0, nw, fa, la, dk, ma, h1);
        check("post_rst_addr", fa, 410);
        check("post_rst_done", dk, 3);

`ifdef RECT_FILL_OUTLINE_EN
        run_cmd(22, 53, 28, 59, 1, 1'b1, nw, fa, la, dk, ma, h1);
        check("outline_nwrites", nw, 24);
        run_cmd(5, 2, 5, 6, 6, 1'b1, nw, fa, la, dk, ma, h1);
        check("outline_thin_nwrites", nw, 5);
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            rx0 = $urandom_range(0, 127);
            ry0 = $urandom_range(0, 63);
            if ($urandom_range(0, 4) == 0) begin
                rx1 = $urandom_range(0, 127);
                ry1 = $urandom_range(0, 63);
            end else begin
                rx1 = rx0 + $urandom_range(0, 15);
                ry1 = ry0 + $urandom_range(0, 8);
                if (rx1 > 127) rx1 = 127;
                if (ry1 > 63) ry1 = 63;
            end
            run_cmd(rx0, ry0, rx1, ry1, $urandom_range(0, 7),
`ifdef RECT_FILL_OUTLINE_EN
                    1'($urandom_range(0, 1)),
`else
                    1'b0,
`endif
                    nw, fa, la, dk, ma, h1);
        end
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
